// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: per-register pending/load/age tracking with stall, flush and
// freeze generation for an in-order pipeline, plus memory-wait timeout and
// saturating stall/flush statistics.
module hazard_scoreboard #(
  parameter int unsigned REG_ADDR_W      = 2,
  parameter int unsigned DATA_FORWARDING = 1,
  parameter int unsigned MAX_MEM_WAIT    = 15,
  parameter int unsigned STAT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic                  use_rs,
  input  logic                  use_rt,
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  input  logic                  id_reg_write,
  input  logic [REG_ADDR_W-1:0] id_write_reg,
  input  logic                  id_is_load,
  input  logic                  wb_commit,
  input  logic [REG_ADDR_W-1:0] wb_write_reg,
  input  logic                  d_mem_read_mem,
  input  logic                  d_ready,
  input  logic                  jump_miss,
  input  logic                  branch_miss,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  bubblify_id,
  output logic                  bubblify_mem,
  output logic                  flush_if,
  output logic                  freeze_ex,
  output logic                  freeze_mem,
  output logic                  incr_num_inst,
  output logic                  mem_timeout,
  output logic [STAT_W-1:0]     stall_cycles,
  output logic [STAT_W-1:0]     flush_count
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;
  localparam int unsigned WAIT_W   = (MAX_MEM_WAIT < 1) ? 1 : $clog2(MAX_MEM_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_MEM_WAIT);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Age encoding: 0 = producer in EX, 1 = MEM, 2 = WB (saturates).
  logic [NUM_REGS-1:0]      pending_q, pending_d;
  logic [NUM_REGS-1:0]      is_load_q, is_load_d;
  logic [NUM_REGS-1:0][1:0] age_q, age_d;
  logic [WAIT_W-1:0]        mem_wait_q, mem_wait_d;
  logic                     mem_timeout_q, mem_timeout_d;
  logic [STAT_W-1:0]        stall_cycles_q, stall_cycles_d;
  logic [STAT_W-1:0]        flush_count_q, flush_count_d;

  logic mem_stall, data_stall, hit_rs, hit_rt, issue;

  assign mem_stall = d_mem_read_mem && !d_ready;

  // Source-operand hit detection; with forwarding only a load still in EX blocks.
  always_comb begin
    hit_rs = pending_q[rs_id];
    hit_rt = pending_q[rt_id];
    if (DATA_FORWARDING != 0) begin
      hit_rs = hit_rs && is_load_q[rs_id] && (age_q[rs_id] == 2'd0);
      hit_rt = hit_rt && is_load_q[rt_id] && (age_q[rt_id] == 2'd0);
    end
    data_stall = id_valid && ((use_rs && hit_rs) || (use_rt && hit_rt));
  end

  assign issue = id_valid && id_reg_write && !mem_stall && !data_stall && !branch_miss;

  // Pipeline control; memory stall dominates, then data stall, then mispredicts.
  always_comb begin
    pc_write     = 1'b1;
    ir_write     = 1'b1;
    bubblify_id  = 1'b0;
    bubblify_mem = 1'b0;
    flush_if     = 1'b0;
    freeze_ex    = 1'b0;
    freeze_mem   = 1'b0;
    if (mem_stall) begin
      pc_write     = 1'b0;
      ir_write     = 1'b0;
      freeze_ex    = 1'b1;
      freeze_mem   = 1'b1;
      bubblify_mem = 1'b1;
    end else if (data_stall) begin
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      bubblify_id = 1'b1;
    end else begin
      if (jump_miss) begin
        flush_if = 1'b1;
      end
      if (branch_miss) begin
        flush_if    = 1'b1;
        bubblify_id = 1'b1;
      end
    end
  end

  assign incr_num_inst = !(bubblify_id || bubblify_mem || !pc_write || flush_if);

  // Scoreboard next state: age, then retire, then issue (issue wins on same register).
  always_comb begin
    pending_d = pending_q;
    is_load_d = is_load_q;
    age_d     = age_q;
    if (!mem_stall) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (pending_q[i] && (age_q[i] != 2'd2)) begin
          age_d[i] = age_q[i] + 2'd1;
        end
      end
    end
    if (wb_commit) begin
      pending_d[wb_write_reg] = 1'b0;
      is_load_d[wb_write_reg] = 1'b0;
      age_d[wb_write_reg]     = 2'd0;
    end
    if (issue) begin
      pending_d[id_write_reg] = 1'b1;
      is_load_d[id_write_reg] = id_is_load;
      age_d[id_write_reg]     = 2'd0;
    end
  end

  // Memory-wait tracking, sticky timeout and saturating statistics.
  always_comb begin
    mem_wait_d    = '0;
    mem_timeout_d = mem_timeout_q;
    if (mem_stall) begin
      mem_wait_d = (mem_wait_q == WAIT_MAX) ? mem_wait_q : mem_wait_q + WAIT_W'(1);
      if (mem_wait_d == WAIT_MAX) begin
        mem_timeout_d = 1'b1;
      end
    end
    stall_cycles_d = stall_cycles_q;
    if (!pc_write && (stall_cycles_q != STAT_MAX)) begin
      stall_cycles_d = stall_cycles_q + STAT_W'(1);
    end
    flush_count_d = flush_count_q;
    if (flush_if && (flush_count_q != STAT_MAX)) begin
      flush_count_d = flush_count_q + STAT_W'(1);
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q      <= '0;
      is_load_q      <= '0;
      age_q          <= '0;
      mem_wait_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      pending_q      <= pending_d;
      is_load_q      <= is_load_d;
      age_q          <= age_d;
      mem_wait_q     <= mem_wait_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances share stimulus (forwarding with 16-bit
// stats, and no forwarding with 4-bit stats), checked against a register-level model.
module tb_hazard_scoreboard;

  localparam int NR   = 4;
  localparam int MAXW = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic id_valid, use_rs, use_rt, id_reg_write, id_is_load, wb_commit;
  logic d_mem_read_mem, d_ready, jump_miss, branch_miss;
  logic [1:0] rs_id, rt_id, id_write_reg, wb_write_reg;

  logic pc_w[2], ir_w[2], bid[2], bmem[2], fl[2], fex[2], fmem[2], inc[2], tmo[2];
  logic [15:0] sc0, fc0;
  logic [3:0]  sc1, fc1;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_ADDR_W(2), .DATA_FORWARDING(1), .MAX_MEM_WAIT(15), .STAT_W(16)) u_fwd (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .use_rs(use_rs), .use_rt(use_rt),
    .rs_id(rs_id), .rt_id(rt_id), .id_reg_write(id_reg_write), .id_write_reg(id_write_reg),
    .id_is_load(id_is_load), .wb_commit(wb_commit), .wb_write_reg(wb_write_reg),
    .d_mem_read_mem(d_mem_read_mem), .d_ready(d_ready), .jump_miss(jump_miss),
    .branch_miss(branch_miss), .pc_write(pc_w[0]), .ir_write(ir_w[0]), .bubblify_id(bid[0]),
    .bubblify_mem(bmem[0]), .flush_if(fl[0]), .freeze_ex(fex[0]), .freeze_mem(fmem[0]),
    .incr_num_inst(inc[0]), .mem_timeout(tmo[0]), .stall_cycles(sc0), .flush_count(fc0)
  );

  hazard_scoreboard #(.REG_ADDR_W(2), .DATA_FORWARDING(0), .MAX_MEM_WAIT(15), .STAT_W(4)) u_nofwd (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .use_rs(use_rs), .use_rt(use_rt),
    .rs_id(rs_id), .rt_id(rt_id), .id_reg_write(id_reg_write), .id_write_reg(id_write_reg),
    .id_is_load(id_is_load), .wb_commit(wb_commit), .wb_write_reg(wb_write_reg),
    .d_mem_read_mem(d_mem_read_mem), .d_ready(d_ready), .jump_miss(jump_miss),
    .branch_miss(branch_miss), .pc_write(pc_w[1]), .ir_write(ir_w[1]), .bubblify_id(bid[1]),
    .bubblify_mem(bmem[1]), .flush_if(fl[1]), .freeze_ex(fex[1]), .freeze_mem(fmem[1]),
    .incr_num_inst(inc[1]), .mem_timeout(tmo[1]), .stall_cycles(sc1), .flush_count(fc1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: one row per instance, register state held as plain integers.
  int m_pend[2][NR];
  int m_ld[2][NR];
  int m_age[2][NR];
  int m_wait[2], m_tmo[2], m_stall[2], m_flush[2];
  int smax[2] = '{65535, 15};
  int dfw[2]  = '{1, 0};

  // Control vector order: {pc, ir, bub_id, bub_mem, flush, frz_ex, frz_mem, incr, timeout}
  typedef struct {
    logic       dmr, drdy, jm, bm, idv, urs;
    logic [1:0] rs;
    logic [8:0] exp_ctrl;
  } vec_t;

  function automatic logic [8:0] act_ctrl(input int k);
    return {pc_w[k], ir_w[k], bid[k], bmem[k], fl[k], fex[k], fmem[k], inc[k], tmo[k]};
  endfunction

  function automatic int act_stall(input int k);
    return (k == 0) ? int'(sc0) : int'(sc1);
  endfunction

  function automatic int act_flush(input int k);
    return (k == 0) ? int'(fc0) : int'(fc1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < NR; r++) begin
        m_pend[k][r] = 0; m_ld[k][r] = 0; m_age[k][r] = 0;
      end
      m_wait[k] = 0; m_tmo[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end
  endtask

  // A source blocks if its producer is pending and (without forwarding) anything,
  // or (with forwarding) a load whose data is not yet out of EX.
  function automatic bit blocks(input int k, input int r);
    if (m_pend[k][r] == 0) return 1'b0;
    if (dfw[k] == 0) return 1'b1;
    return (m_ld[k][r] != 0) && (m_age[k][r] == 0);
  endfunction

  task automatic model_ctrl(input int k, output logic [8:0] c, output bit ms, output bit ds);
    bit stall, bub, flush;
    ms    = d_mem_read_mem && !d_ready;
    ds    = id_valid && ((use_rs && blocks(k, int'(rs_id))) || (use_rt && blocks(k, int'(rt_id))));
    stall = ms || ds;
    bub   = !ms && (ds || branch_miss);
    flush = !stall && (jump_miss || branch_miss);
    c = {!stall, !stall, bub, ms, flush, ms, ms, !stall && !bub && !flush, m_tmo[k] != 0};
  endtask

  task automatic model_step(input int k);
    logic [8:0] c;
    bit ms, ds, issue;
    model_ctrl(k, c, ms, ds);
    issue = id_valid && id_reg_write && !ms && !ds && !branch_miss;
    if (!ms)
      for (int r = 0; r < NR; r++)
        if (m_pend[k][r] != 0 && m_age[k][r] < 2) m_age[k][r]++;
    if (wb_commit) m_pend[k][wb_write_reg] = 0;
    if (issue) begin
      m_pend[k][id_write_reg] = 1;
      m_ld[k][id_write_reg]   = id_is_load ? 1 : 0;
      m_age[k][id_write_reg]  = 0;
    end
    m_wait[k] = ms ? ((m_wait[k] < MAXW) ? m_wait[k] + 1 : MAXW) : 0;
    if (ms && m_wait[k] == MAXW) m_tmo[k] = 1;
    if (!c[8] && m_stall[k] < smax[k]) m_stall[k]++;
    if (c[4] && m_flush[k] < smax[k]) m_flush[k]++;
  endtask

  // Compare both instances against the model; called mid-cycle on the falling edge.
  task automatic sample();
    logic [8:0] c;
    bit ms, ds;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      model_ctrl(k, c, ms, ds);
      check($sformatf("ctrl%0d", k), int'(act_ctrl(k)), int'(c));
      check($sformatf("stall_cycles%0d", k), act_stall(k), m_stall[k]);
      check($sformatf("flush_count%0d", k), act_flush(k), m_flush[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
    cyc++;
  endtask

  task automatic idle();
    id_valid = 0; use_rs = 0; use_rt = 0; rs_id = 0; rt_id = 0;
    id_reg_write = 0; id_write_reg = 0; id_is_load = 0;
    wb_commit = 0; wb_write_reg = 0; d_mem_read_mem = 0; d_ready = 1;
    jump_miss = 0; branch_miss = 0;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset_ctrl%0d", k), int'(act_ctrl(k)), int'(9'b110000010));
      check($sformatf("reset_stall%0d", k), act_stall(k), 0);
      check($sformatf("reset_flush%0d", k), act_flush(k), 0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic issue_reg(input logic [1:0] r, input logic ld);
    idle();
    id_valid = 1; id_reg_write = 1; id_write_reg = r; id_is_load = ld;
  endtask

  task automatic read_reg(input logic [1:0] r);
    idle();
    id_valid = 1; use_rs = 1; rs_id = r;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{dmr:0, drdy:1, jm:0, bm:0, idv:0, urs:0, rs:0, exp_ctrl:9'b110000010};
    vecs[1] = '{dmr:1, drdy:0, jm:0, bm:0, idv:0, urs:0, rs:0, exp_ctrl:9'b000101100};
    vecs[2] = '{dmr:1, drdy:1, jm:0, bm:0, idv:0, urs:0, rs:0, exp_ctrl:9'b110000010};
    vecs[3] = '{dmr:0, drdy:1, jm:1, bm:0, idv:0, urs:0, rs:0, exp_ctrl:9'b110010000};
    vecs[4] = '{dmr:0, drdy:1, jm:0, bm:1, idv:0, urs:0, rs:0, exp_ctrl:9'b111010000};
    vecs[5] = '{dmr:1, drdy:0, jm:0, bm:1, idv:0, urs:0, rs:0, exp_ctrl:9'b000101100};
    vecs[6] = '{dmr:0, drdy:1, jm:1, bm:1, idv:0, urs:0, rs:0, exp_ctrl:9'b111010000};
    vecs[7] = '{dmr:0, drdy:1, jm:0, bm:0, idv:1, urs:1, rs:1, exp_ctrl:9'b110000010};

    idle();
    model_reset();
    do_reset();

    // Single-cycle control decode from an empty scoreboard.
    for (int i = 0; i < 8; i++) begin
      idle();
      d_mem_read_mem = vecs[i].dmr; d_ready = vecs[i].drdy;
      jump_miss = vecs[i].jm; branch_miss = vecs[i].bm;
      id_valid = vecs[i].idv; use_rs = vecs[i].urs; rs_id = vecs[i].rs;
      sample();
      for (int k = 0; k < 2; k++)
        check($sformatf("vec%0d_dut%0d", i, k), int'(act_ctrl(k)), int'(vecs[i].exp_ctrl));
      tick();
    end

    // Load-use with forwarding: exactly one bubble, then clean issue.
    do_reset();
    issue_reg(2'd1, 1'b1);
    sample(); check("lu_issue_pc", pc_w[0], 1); tick();
    read_reg(2'd1);
    sample(); check("lu_stall_pc", pc_w[0], 0); check("lu_stall_bub", bid[0], 1); tick();
    sample(); check("lu_go_pc", pc_w[0], 1); check("lu_go_inc", inc[0], 1); tick();

    // No forwarding: stall on ALU producer until the commit cycle has passed.
    do_reset();
    issue_reg(2'd2, 1'b0);
    sample(); tick();
    idle(); id_valid = 1; use_rt = 1; rt_id = 2'd2;
    for (int i = 0; i < 3; i++) begin
      sample(); check("nf_wait_pc", pc_w[1], 0); check("nf_fwd_pc", pc_w[0], 1); tick();
    end
    wb_commit = 1; wb_write_reg = 2'd2;
    sample(); check("nf_commit_cycle_pc", pc_w[1], 0); tick();
    wb_commit = 0;
    sample(); check("nf_after_commit_pc", pc_w[1], 1); tick();

    // Four-cycle memory stall: freezes, ages hold, stall count +4.
    do_reset();
    issue_reg(2'd3, 1'b1);
    sample(); tick();
    idle(); d_mem_read_mem = 1; d_ready = 0;
    for (int i = 0; i < 4; i++) begin
      sample(); check("ms_frz_ex", fex[0], 1); check("ms_frz_mem", fmem[0], 1); tick();
    end
    read_reg(2'd3);
    sample(); check("ms_stall_count", int'(sc0), 4); check("ms_age_held", pc_w[0], 0); tick();

    // Timeout after MAX_MEM_WAIT stalled cycles, sticky afterwards.
    do_reset();
    idle(); d_mem_read_mem = 1; d_ready = 0;
    for (int i = 0; i < MAXW; i++) begin
      sample();
      if (i == MAXW - 1) check("tmo_before", tmo[0], 0);
      tick();
    end
    d_ready = 1;
    sample(); check("tmo_set", tmo[0], 1); tick();
    idle();
    sample(); check("tmo_sticky", tmo[0], 1); tick();

    // Branch miss vs load-use stall, then branch miss alone.
    do_reset();
    issue_reg(2'd1, 1'b1);
    sample(); tick();
    read_reg(2'd1); branch_miss = 1;
    sample(); check("bm_ds_flush", fl[0], 0); check("bm_ds_bub", bid[0], 1); tick();
    idle(); branch_miss = 1;
    sample(); check("bm_flush", fl[0], 1); check("bm_bub", bid[0], 1); tick();
    idle();
    sample(); check("bm_flush_count", int'(fc0), 1); tick();

    // Issue and commit to the same register: issue wins, entry pending at age 0.
    do_reset();
    issue_reg(2'd2, 1'b1); wb_commit = 1; wb_write_reg = 2'd2;
    sample(); tick();
    read_reg(2'd2);
    sample(); check("ic_pend_fwd", pc_w[0], 0); check("ic_pend_nofwd", pc_w[1], 0); tick();
    // Mid-cycle asynchronous reset abandons the stall at once.
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_pc", pc_w[1], 1); check("rst_mid_stall", int'(sc1), 0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    sample(); tick();

    // Stat saturation on the 4-bit instance.
    do_reset();
    idle(); d_mem_read_mem = 1; d_ready = 0;
    for (int i = 0; i < 20; i++) begin sample(); tick(); end
    idle();
    sample(); check("sat_nofwd", int'(sc1), 15); check("sat_fwd", int'(sc0), 20); tick();

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      id_valid       = ($urandom_range(0, 3) != 0);
      use_rs         = $urandom_range(0, 1) == 1;
      use_rt         = $urandom_range(0, 1) == 1;
      rs_id          = 2'($urandom_range(0, 3));
      rt_id          = 2'($urandom_range(0, 3));
      id_reg_write   = ($urandom_range(0, 2) != 0);
      id_write_reg   = 2'($urandom_range(0, 3));
      id_is_load     = $urandom_range(0, 1) == 1;
      wb_commit      = ($urandom_range(0, 2) == 0);
      wb_write_reg   = 2'($urandom_range(0, 3));
      d_mem_read_mem = ($urandom_range(0, 3) == 0);
      d_ready        = ($urandom_range(0, 2) != 0);
      jump_miss      = ($urandom_range(0, 9) == 0);
      branch_miss    = ($urandom_range(0, 9) == 0);
      sample();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
